// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite slave fronting a word-addressed SRAM with byte strobes
// The accepted beat is held in data-phase registers; its SRAM write lands on the edge closing the data phase.
module ahb_sram_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP
);
   localparam int NB     = DATA_W / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int IDX_W  = ADDR_W - OFF_W;
   localparam int MEM_AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [2:0]        wait_cnt_q, wait_cnt_d;
   logic              wr_pend_q;
   logic [MEM_AW-1:0] dp_idx_q;
   logic [NB-1:0]     dp_strb_q;
   logic [DATA_W-1:0] hrdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  acc_idx;
   logic [OFF_W-1:0]  acc_off;
   logic [NB-1:0]     acc_strb;
   logic              acc, acc_err, commit, wait_last;
   logic [DATA_W-1:0] fwd_word;
   int                size_bytes;
   logic              unused_trans0;

   assign acc_idx       = HADDR[ADDR_W-1:OFF_W];
   assign acc_off       = HADDR[OFF_W-1:0];
   assign acc           = HSEL & HREADY & HTRANS[1] & HREADYOUT;
   assign commit        = wr_pend_q & (state_q == S_IDLE);
   assign wait_last     = (int'(wait_cnt_q) == WAIT_STATES - 1);
   assign HRDATA        = hrdata_q;
   assign unused_trans0 = HTRANS[0];

   always_comb begin
      size_bytes = 1 << HSIZE;
      acc_err = (size_bytes > NB) || ((int'(acc_off) & (size_bytes - 1)) != 0) ||
                (int'(acc_idx) >= DEPTH);
      for (int k = 0; k < NB; k++)
         acc_strb[k] = (k >= int'(acc_off)) && (k < int'(acc_off) + size_bytes);
   end

   // A read landing on the word whose write completes this edge sees the merged value.
   always_comb begin
      fwd_word = mem[acc_idx[MEM_AW-1:0]];
      if (commit && dp_idx_q == acc_idx[MEM_AW-1:0])
         for (int k = 0; k < NB; k++)
            if (dp_strb_q[k]) fwd_word[8*k +: 8] = HWDATA[8*k +: 8];
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      case (state_q)
         S_WAIT: begin
            HREADYOUT  = 1'b0;
            wait_cnt_d = wait_cnt_q + 3'd1;
            if (wait_last) state_d = S_IDLE;
         end
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = S_ERR2;
         end
         S_ERR2: begin
            HRESP   = 1'b1;
            state_d = S_IDLE;
         end
         default: ;
      endcase
      if (acc) begin
         wait_cnt_d = '0;
         if (acc_err)              state_d = S_ERR1;
         else if (WAIT_STATES > 0) state_d = S_WAIT;
         else                      state_d = S_IDLE;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         wr_pend_q  <= 1'b0;
         dp_idx_q   <= '0;
         dp_strb_q  <= '0;
         hrdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (commit) wr_pend_q <= 1'b0;
         if (acc) begin
            wr_pend_q <= HWRITE & ~acc_err;
            dp_idx_q  <= acc_idx[MEM_AW-1:0];
            dp_strb_q <= acc_strb;
            if (!HWRITE && acc_err)              hrdata_q <= '0;
            else if (!HWRITE && WAIT_STATES == 0) hrdata_q <= fwd_word;
         end else if (state_q == S_WAIT && wait_last && !wr_pend_q) begin
            hrdata_q <= mem[dp_idx_q];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (commit)
         for (int k = 0; k < NB; k++)
            if (dp_strb_q[k]) mem[dp_idx_q][8*k +: 8] <= HWDATA[8*k +: 8];
   end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - randomized bench for ahb_sram_slave against a sequential memory model
// dut0 runs with no wait states, dut2 with two; each has its own select and reset.
module tb_ahb_sram_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn0, rstn2, sel0, sel2, hwrite;
   logic [15:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata, hrdata0, hrdata2;
   logic        hro0, hro2, hresp0, hresp2;

   ahb_sram_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESETn(rstn0), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro0), .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0));
   ahb_sram_slave #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_STATES(2)) dut2 (
      .HCLK(clk), .HRESETn(rstn2), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
      .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hro2), .HRDATA(hrdata2), .HREADYOUT(hro2), .HRESP(hresp2));

   typedef struct {
      logic [15:0] addr;
      logic [2:0]  size;
      bit          write;
      bit          idle;
      logic [31:0] wdata;
   } xfer_t;

   xfer_t       tq[$];
   logic [31:0] ob_rdata [512];
   bit          ob_resp_first [512];
   bit          ob_resp [512];
   bit          ob_done [512];
   int          ob_stall [512];
   logic [31:0] ref_mem [2][1024];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic void push(input logic [15:0] a, input logic [2:0] s, input bit w, input logic [31:0] d);
      xfer_t t;
      t.addr = a; t.size = s; t.write = w; t.idle = 1'b0; t.wdata = d;
      tq.push_back(t);
   endfunction

   function automatic void push_idle();
      xfer_t t;
      t.addr = '0; t.size = '0; t.write = 1'b0; t.idle = 1'b1; t.wdata = '0;
      tq.push_back(t);
   endfunction

   // Transfers take effect in issue order; an errored beat changes nothing and reads back zero.
   function automatic void model_step(input int m, input xfer_t t, output bit err, output logic [31:0] exp_rd);
      int sz, idx, off;
      sz  = 1 << t.size;
      idx = int'(t.addr) / 4;
      off = int'(t.addr) % 4;
      err = (sz > 4) || ((off % sz) != 0) || (idx >= 1024);
      exp_rd = '0;
      if (!err && t.write)
         for (int b = 0; b < 4; b++)
            if (b >= off && b < off + sz) ref_mem[m][idx][8*b +: 8] = t.wdata[8*b +: 8];
      if (!err && !t.write) exp_rd = ref_mem[m][idx];
   endfunction

   // Pipelined master: issues tq in order on the chosen DUT and records each beat's data phase.
   task automatic run_q(input int m);
      int a = 0, d = -1, stall = 0, n;
      bit first = 1'b0, rdy, resp;
      logic [31:0] rd;
      n = tq.size();
      for (int i = 0; i < n; i++) ob_done[i] = 1'b0;
      for (int cyc = 0; cyc < 64 * (n + 2) && (a < n || d >= 0); cyc++) begin
         @(negedge clk);
         rdy  = (m == 0) ? hro0 : hro2;
         resp = (m == 0) ? hresp0 : hresp2;
         rd   = (m == 0) ? hrdata0 : hrdata2;
         if (d >= 0) begin
            if (first) begin ob_resp_first[d] = resp; first = 1'b0; end
            if (rdy) begin
               ob_rdata[d] = rd; ob_resp[d] = resp; ob_stall[d] = stall; ob_done[d] = 1'b1; stall = 0;
            end else stall++;
         end
         hwdata = (d >= 0) ? tq[d].wdata : 32'h0;
         if (a < n) begin
            sel0 = (m == 0); sel2 = (m == 1);
            haddr = tq[a].addr; htrans = tq[a].idle ? 2'b00 : 2'b10;
            hwrite = tq[a].write; hsize = tq[a].size;
         end else begin
            sel0 = 1'b0; sel2 = 1'b0; htrans = 2'b00;
         end
         if (rdy) begin
            d = (a < n && !tq[a].idle) ? a : -1;
            first = (d >= 0);
            if (a < n) a++;
         end
      end
      @(negedge clk);
      sel0 = 1'b0; sel2 = 1'b0; htrans = 2'b00; hwdata = 32'h0;
   endtask

   task automatic init_mem(input int m);
      bit err; logic [31:0] exp;
      tq.delete();
      for (int i = 0; i < 64; i++) push(16'(i * 4), 3'd2, 1'b1, $urandom);
      run_q(m);
      foreach (tq[i]) model_step(m, tq[i], err, exp);
   endtask

   task automatic test_reset();
      rstn0 = 1'b0; rstn2 = 1'b0; sel0 = 1'b0; sel2 = 1'b0;
      haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (hro0 !== 1'b1) begin n_err++; $display("FAIL reset_hreadyout0 got %b want 1", hro0); end
      n_vec++; if (hresp0 !== 1'b0) begin n_err++; $display("FAIL reset_hresp0 got %b want 0", hresp0); end
      n_vec++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL reset_hrdata0 got %h want 0", hrdata0); end
      n_vec++; if (hro2 !== 1'b1) begin n_err++; $display("FAIL reset_hreadyout2 got %b want 1", hro2); end
      n_vec++; if (hresp2 !== 1'b0) begin n_err++; $display("FAIL reset_hresp2 got %b want 0", hresp2); end
      n_vec++; if (hrdata2 !== 32'h0) begin n_err++; $display("FAIL reset_hrdata2 got %h want 0", hrdata2); end
      rstn0 = 1'b1; rstn2 = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      bit err; logic [31:0] exp;
      int ri[4] = '{1, 4, 6, 9};
      logic [31:0] rv[4] = '{32'hDEADBEEF, 32'hDEABBEEF, 32'h12345678, 32'hDEABBEEF};
      int wi[3] = '{0, 2, 5};
      int ei[2] = '{7, 8};
      tq.delete();
      push(16'h0010, 3'd2, 1'b1, 32'hDEADBEEF);
      push(16'h0010, 3'd2, 1'b0, 32'h0);
      push(16'h0012, 3'd0, 1'b1, 32'h00AB0000);
      push_idle();
      push(16'h0010, 3'd2, 1'b0, 32'h0);
      push(16'h0020, 3'd2, 1'b1, 32'h12345678);
      push(16'h0020, 3'd2, 1'b0, 32'h0);
      push(16'h1000, 3'd2, 1'b1, 32'h55AA55AA);
      push(16'h0011, 3'd1, 1'b1, 32'hFFFFFFFF);
      push(16'h0010, 3'd2, 1'b0, 32'h0);
      run_q(0);
      foreach (tq[i]) if (!tq[i].idle) model_step(0, tq[i], err, exp);
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (!ob_done[ri[k]] || ob_rdata[ri[k]] !== rv[k] || ob_resp[ri[k]] || ob_stall[ri[k]] != 0) begin
            n_err++;
            $display("FAIL directed_read%0d got data=%h resp=%b stall=%0d done=%b want data=%h resp=0 stall=0",
                     ri[k], ob_rdata[ri[k]], ob_resp[ri[k]], ob_stall[ri[k]], ob_done[ri[k]], rv[k]);
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (!ob_done[wi[k]] || ob_resp[wi[k]] || ob_stall[wi[k]] != 0) begin
            n_err++;
            $display("FAIL directed_write%0d got resp=%b stall=%0d done=%b want resp=0 stall=0",
                     wi[k], ob_resp[wi[k]], ob_stall[wi[k]], ob_done[wi[k]]);
         end
      end
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if (!ob_done[ei[k]] || !ob_resp_first[ei[k]] || !ob_resp[ei[k]] || ob_stall[ei[k]] != 1) begin
            n_err++;
            $display("FAIL directed_error%0d got resp=%b/%b stall=%0d done=%b want resp=1/1 stall=1",
                     ei[k], ob_resp_first[ei[k]], ob_resp[ei[k]], ob_stall[ei[k]], ob_done[ei[k]]);
         end
      end
   endtask

   task automatic test_random_traffic(input int m, input int n);
      bit err; logic [31:0] exp; int ws, r, xs; logic [15:0] a; logic [2:0] s;
      ws = (m == 0) ? 0 : 2;
      tq.delete();
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         s = 3'($urandom_range(0, 3));
         a = (r < 16) ? 16'(32'h1000 + $urandom_range(0, 32'hEFFF)) : 16'($urandom_range(0, 255));
         if (r >= 30) a = a & ~16'((1 << s) - 1);
         if (r < 8) push_idle();
         else push(a, s, $urandom_range(0, 1) == 1, $urandom);
      end
      run_q(m);
      for (int i = 0; i < n; i++) begin
         if (tq[i].idle) continue;
         model_step(m, tq[i], err, exp);
         xs = err ? 1 : ws;
         n_vec++;
         if (!ob_done[i] || ob_resp_first[i] !== err || ob_resp[i] !== err || ob_stall[i] != xs) begin
            n_err++;
            $display("FAIL rand%0d_resp beat %0d got resp=%b/%b stall=%0d done=%b want resp=%b/%b stall=%0d",
                     m, i, ob_resp_first[i], ob_resp[i], ob_stall[i], ob_done[i], err, err, xs);
         end
         if (!tq[i].write) begin
            n_vec++;
            if (ob_rdata[i] !== exp) begin
               n_err++;
               $display("FAIL rand%0d_rdata beat %0d addr %h got %h want %h", m, i, tq[i].addr, ob_rdata[i], exp);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit err; logic [31:0] exp; int w; logic [2:0] s; logic [15:0] a;
      tq.delete();
      for (int i = 0; i < 40; i++) begin
         s = 3'($urandom_range(0, 2));
         w = $urandom_range(0, 63);
         a = 16'(w * 4 + ($urandom_range(0, 3) & ~((1 << s) - 1)));
         push(a, s, 1'b1, $urandom);
         push(16'(w * 4), 3'd2, 1'b0, 32'h0);
      end
      run_q(0);
      for (int i = 0; i < 80; i++) begin
         model_step(0, tq[i], err, exp);
         if (tq[i].write) continue;
         n_vec++;
         if (!ob_done[i] || ob_stall[i] != 0 || ob_resp[i] || ob_rdata[i] !== exp) begin
            n_err++;
            $display("FAIL b2b_forward beat %0d addr %h got %h stall=%0d resp=%b want %h stall=0 resp=0",
                     i, tq[i].addr, ob_rdata[i], ob_stall[i], ob_resp[i], exp);
         end
      end
   endtask

   task automatic test_wait_states();
      bit err; logic [31:0] exp;
      tq.delete();
      push(16'h0010, 3'd2, 1'b1, 32'hDEADBEEF);
      push(16'h0012, 3'd0, 1'b1, 32'h00AB0000);
      push(16'h0010, 3'd2, 1'b0, 32'h0);
      run_q(1);
      foreach (tq[i]) model_step(1, tq[i], err, exp);
      n_vec++;
      if (!ob_done[2] || ob_stall[2] != 2 || ob_resp[2] || ob_rdata[2] !== 32'hDEABBEEF) begin
         n_err++;
         $display("FAIL wait_read got %h stall=%0d resp=%b want DEABBEEF stall=2 resp=0",
                  ob_rdata[2], ob_stall[2], ob_resp[2]);
      end
      n_vec++;
      if (!ob_done[0] || !ob_done[1] || ob_stall[0] != 2 || ob_stall[1] != 2) begin
         n_err++;
         $display("FAIL wait_writes got stall=%0d,%0d want 2,2", ob_stall[0], ob_stall[1]);
      end
   endtask

   task automatic test_reset_mid();
      bit err; logic [31:0] exp;
      @(negedge clk);
      sel2 = 1'b1; haddr = 16'h0030; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
      @(negedge clk);
      sel2 = 1'b0; htrans = 2'b00; hwdata = ~ref_mem[1][12];
      n_vec++; if (hro2 !== 1'b0) begin n_err++; $display("FAIL midrst_in_wait got hreadyout=%b want 0", hro2); end
      #1 rstn2 = 1'b0;
      #1;
      n_vec++; if (hro2 !== 1'b1) begin n_err++; $display("FAIL midrst_hreadyout got %b want 1", hro2); end
      n_vec++; if (hresp2 !== 1'b0) begin n_err++; $display("FAIL midrst_hresp got %b want 0", hresp2); end
      n_vec++; if (hrdata2 !== 32'h0) begin n_err++; $display("FAIL midrst_hrdata got %h want 0", hrdata2); end
      @(negedge clk);
      rstn2 = 1'b1; hwdata = 32'h0;
      tq.delete();
      push(16'h0030, 3'd2, 1'b0, 32'h0);
      run_q(1);
      model_step(1, tq[0], err, exp);
      n_vec++;
      if (!ob_done[0] || ob_stall[0] != 2 || ob_resp[0] || ob_rdata[0] !== exp) begin
         n_err++;
         $display("FAIL midrst_dropped_write got %h stall=%0d resp=%b want %h stall=2 resp=0",
                  ob_rdata[0], ob_stall[0], ob_resp[0], exp);
      end
   endtask

   initial begin
      test_reset();
      init_mem(0);
      init_mem(1);
      test_directed();
      test_random_traffic(0, 200);
      test_back_to_back();
      test_wait_states();
      test_random_traffic(1, 80);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
